// File: rtl/game_over_detector_pkg.sv
// Shared 2048 board definitions: directions, cell/row geometry, FSM states, transpose helper.
package game_over_detector_pkg;

  localparam logic [1:0] DIRECTION_LEFT  = 2'd0;
  localparam logic [1:0] DIRECTION_RIGHT = 2'd1;
  localparam logic [1:0] DIRECTION_UP    = 2'd2;
  localparam logic [1:0] DIRECTION_DOWN  = 2'd3;

  localparam int unsigned CELL_W = 4;
  localparam int unsigned ROW_W  = 16;

  typedef enum logic {
    StIdle,
    StScan
  } god_state_e;

  // Swap rows and columns so vertical moves can reuse the horizontal row datapath.
  function automatic logic [63:0] transpose_grid(input logic [63:0] g);
    logic [63:0] t;
    t = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        t[(r*4+c)*CELL_W +: CELL_W] = g[(c*4+r)*CELL_W +: CELL_W];
      end
    end
    return t;
  endfunction

endpackage

// File: rtl/game_row_push_merge.sv
// One 2048 row move: slide non-empty cells toward cell 0 (or cell 3) and merge equal pairs once.
module game_row_push_merge
  import game_over_detector_pkg::*;
(
  input  logic [ROW_W-1:0] row_i,
  input  logic             push_right_i,
  output logic [ROW_W-1:0] result_o
);

  logic [CELL_W-1:0] in_c  [4];
  logic [CELL_W-1:0] cmp_c [5];  // extra zero slot keeps the pair look-ahead in range
  logic [CELL_W-1:0] out_c [4];
  logic [1:0]        wr_j;
  logic [1:0]        wr_k;
  logic              skip;

  // Compress non-empty cells to the front, then merge adjacent equal pairs left to right.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      in_c[i]  = push_right_i ? row_i[(3-i)*CELL_W +: CELL_W] : row_i[i*CELL_W +: CELL_W];
      out_c[i] = '0;
    end
    for (int i = 0; i < 5; i++) begin
      cmp_c[i] = '0;
    end
    wr_j = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (in_c[i] != '0) begin
        cmp_c[wr_j] = in_c[i];
        wr_j        = wr_j + 2'd1;
      end
    end
    wr_k = 2'd0;
    skip = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (skip) begin
        skip = 1'b0;
      end else if (cmp_c[i] != '0) begin
        if (cmp_c[i] == cmp_c[i+1]) begin
          out_c[wr_k] = (cmp_c[i] == 4'hF) ? 4'hF : cmp_c[i] + 4'd1;
          skip        = 1'b1;
        end else begin
          out_c[wr_k] = cmp_c[i];
        end
        wr_k = wr_k + 2'd1;
      end
    end
    result_o = '0;
    for (int i = 0; i < 4; i++) begin
      if (push_right_i) begin
        result_o[(3-i)*CELL_W +: CELL_W] = out_c[i];
      end else begin
        result_o[i*CELL_W +: CELL_W] = out_c[i];
      end
    end
  end

endmodule

// File: rtl/game_over_detector.sv
// Scans a board snapshot one row per cycle over all four directions and reports
// which moves are possible, whether the game is over, and whether a win tile exists.
module game_over_detector
  import game_over_detector_pkg::*;
#(
  parameter logic [3:0] WIN_TILE = 4'd11
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        clear,
  input  logic [63:0] grid,
  output logic        busy,
  output logic        done,
  output logic [3:0]  moves_available,
  output logic        game_over,
  output logic        win
);

  god_state_e  state_q, state_d;
  logic [3:0]  s_q, s_d;
  logic [63:0] snap_q, snap_d;
  logic [3:0]  acc_q, acc_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [3:0]  moves_q, moves_d;
  logic        game_over_q, game_over_d;
  logic        win_q, win_d;

  logic [63:0]      snap_t;
  logic [1:0]       dir;
  logic [ROW_W-1:0] row_sel;
  logic [ROW_W-1:0] row_res;
  logic             push_right;
  logic             snap_win;

  assign snap_t     = transpose_grid(snap_q);
  assign dir        = s_q[3:2];
  assign push_right = (dir == DIRECTION_RIGHT) || (dir == DIRECTION_DOWN);
  assign row_sel    = dir[1] ? snap_t[{s_q[1:0], 4'b0000} +: ROW_W]
                             : snap_q[{s_q[1:0], 4'b0000} +: ROW_W];

  game_row_push_merge u_push_merge (
    .row_i        (row_sel),
    .push_right_i (push_right),
    .result_o     (row_res)
  );

  // Win check over every snapshot cell.
  always_comb begin
    snap_win = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (snap_q[i*CELL_W +: CELL_W] >= WIN_TILE) begin
        snap_win = 1'b1;
      end
    end
  end

  // Next-state: accept start in idle, accumulate one row per scan cycle, publish at s=15.
  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    snap_d      = snap_q;
    acc_d       = acc_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    moves_d     = moves_q;
    game_over_d = game_over_q;
    win_d       = win_q;
    unique case (state_q)
      StIdle: begin
        if (start && !clear) begin
          snap_d  = grid;
          acc_d   = 4'b0000;
          s_d     = 4'd0;
          busy_d  = 1'b1;
          state_d = StScan;
        end
      end
      StScan: begin
        if (clear) begin
          busy_d  = 1'b0;
          state_d = StIdle;
        end else begin
          acc_d[dir] = acc_q[dir] | (row_sel != row_res);
          if (s_q == 4'd15) begin
            busy_d      = 1'b0;
            done_d      = 1'b1;
            moves_d     = acc_d;
            game_over_d = (acc_d == 4'b0000);
            win_d       = snap_win;
            state_d     = StIdle;
          end else begin
            s_d = s_q + 4'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Single state register for the FSM, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      s_q         <= 4'd0;
      snap_q      <= '0;
      acc_q       <= 4'b0000;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      moves_q     <= 4'b0000;
      game_over_q <= 1'b0;
      win_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      snap_q      <= snap_d;
      acc_q       <= acc_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      moves_q     <= moves_d;
      game_over_q <= game_over_d;
      win_q       <= win_d;
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign moves_available = moves_q;
  assign game_over       = game_over_q;
  assign win             = win_q;

endmodule

// File: doc/game_over_detector.md
GAME_OVER_DETECTOR -- requirements
Module: game_over_detector

Interface
REQ-001 SHALL have parameter WIN_TILE, default 4'd11, the tile exponent that counts as a win (11 = 2048).
REQ-002 SHALL have port clk, input, 1 bit: the single clock.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port start, input, 1 bit: request a scan; sampled only in IDLE.
REQ-005 SHALL have port clear, input, 1 bit: synchronous abort of a scan in progress.
REQ-006 SHALL have port grid, input, 64 bits: board; row r = grid[r*16+:16], cell i = grid[i*4+:4].
REQ-007 SHALL have port busy, output, 1 bit: scan in progress.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse, results valid.
REQ-009 SHALL have port moves_available, output, 4 bits: per-direction move possible; bit0 left, bit1 right, bit2 up, bit3 down.
REQ-010 SHALL have port game_over, output, 1 bit: no direction changes the board.
REQ-011 SHALL have port win, output, 1 bit: some cell >= WIN_TILE.

Function
REQ-012 SHALL implement a two-state FSM, IDLE and SCAN, plus a 4-bit step counter s.
REQ-013 SHALL, in IDLE with start=1 and clear=0, latch grid into a snapshot register, clear the move accumulator, set s=0 and enter SCAN; busy SHALL be 1 from the next cycle.
REQ-014 SHALL evaluate exactly one row per SCAN cycle with one shared push-merge instance: direction d=s[3:2] (0 left, 1 right, 2 up, 3 down), row index s[1:0].
REQ-015 SHALL feed the snapshot row for d<2 and the transposed-snapshot row for d>=2; push_right SHALL be 1 for d=1 or d=3.
REQ-016 SHALL OR (row != result) into accumulator bit d each SCAN cycle.
REQ-017 SHALL, at the edge where s=15, return to IDLE, drop busy, and pulse done for one cycle.
REQ-018 SHALL, at the same edge as REQ-017, register moves_available = accumulator, game_over = (accumulator == 0) and win = (any snapshot nibble >= WIN_TILE).
REQ-019 SHALL make busy high for exactly 16 cycles, with done asserted 16 cycles after the edge sampling start.
REQ-020 SHALL hold result outputs until the next done; they SHALL NOT change during a scan.
REQ-021 SHALL ignore start while in SCAN; start coincident with done (state IDLE) SHALL be accepted.
REQ-022 SHALL base the result on the snapshot only; changes on grid during SCAN SHALL be ignored.
REQ-023 SHALL, on clear in SCAN, go to IDLE next cycle with busy=0, no done pulse, and prior results retained; clear has priority over start.
REQ-024 SHALL never modify the board; the block is read-only.

Reset
REQ-025 SHALL, on rst_n=0 at any time including mid-scan, immediately force IDLE with busy, done, moves_available, game_over, win, s and snapshot all 0.
REQ-026 SHALL require a fresh start after reset release; no scan resumes.

Structure
REQ-027 SHALL place DIRECTION_LEFT/RIGHT/UP/DOWN (2'd0..3), the cell width (4), the row width (16) and the grid transpose function in a shared package reused with game_logic.
REQ-028 SHALL instantiate exactly one game_row_push_merge as its sub-module; no duplicated merge logic.

Verification
REQ-029 SHALL cover: all-zero grid, start -> done 16 cycles later, moves_available=4'b0000, game_over=1, win=0.
REQ-030 SHALL cover: checkerboard grid=64'h2121_1212_2121_1212 -> moves_available=4'b0000, game_over=1, win=0.
REQ-031 SHALL cover: all cells 1 (64'h1111_1111_1111_1111) -> moves_available=4'b1111, game_over=0.
REQ-032 SHALL cover: checkerboard with cell 0 = 4'hB -> win=1, game_over=1; with WIN_TILE=4'hC -> win=0.
REQ-033 SHALL cover: start checkerboard, switch grid to all-1s at SCAN cycle 3 and pulse start at cycle 5 -> single done at cycle 16, game_over=1.
REQ-034 SHALL cover: clear at cycle 8 -> busy=0 next cycle, no done, previous results held; rst_n low at cycle 4 -> all outputs 0 immediately.
